// File: rtl/obstacle_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_lane_scheduler
// Description : Multiplexes the obstacle lanes onto one shared position-update
//               datapath. It derives a movement tick from the score band. On
//               each tick it issues one step request per lane, in round-robin
//               order. On a level-up it freezes traffic for a fixed number of
//               ticks, then reloads a pseudo-random direction pattern.
// Ports       : i_Clk, i_Reset      - clock, synchronous active-high reset
//               i_Score             - score selecting the tick period band
//               i_Level_Up          - single-cycle level-up request
//               i_Pause             - holds the tick counter while high
//               i_Step_Ready        - datapath accepts the current step
//               o_Step_*            - registered step request (valid/lane/
//                                     amount/direction)
//               o_Reverse           - per-lane direction vector (1 = R-to-L)
//               o_Freeze            - traffic frozen after a level-up
//               o_Level_Ack         - one-cycle pulse when a pattern loads
//               o_Level             - level count, saturating at 15
//               o_Overrun           - sticky: tick arrived mid-round
// Options     : define OBST_SCHED_LANE_MASK_EN to add i_Lane_Mask. Masked
//               lanes are skipped without spending a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_lane_scheduler #(
    parameter int unsigned         C_BASE_CAR_SPEED = 781250,
    parameter int unsigned         C_NB_CARS        = 4,
    parameter int unsigned         NUM_BITS         = 4,
    parameter int unsigned         C_FREEZE_TICKS   = 64,
    parameter logic [NUM_BITS-1:0] C_INIT_REVERSE   = 4'b1010,
    parameter logic [7:0]          C_LFSR_SEED      = 8'hA5
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic [5:0]          i_Score,
    input  logic                i_Level_Up,
    input  logic                i_Pause,
    input  logic                i_Step_Ready,
`ifdef OBST_SCHED_LANE_MASK_EN
    input  logic [NUM_BITS-1:0] i_Lane_Mask,
`endif
    output logic                o_Step_Valid,
    output logic [1:0]          o_Step_Lane,
    output logic [2:0]          o_Step_Amount,
    output logic                o_Step_Reverse,
    output logic [NUM_BITS-1:0] o_Reverse,
    output logic                o_Freeze,
    output logic                o_Level_Ack,
    output logic [3:0]          o_Level,
    output logic                o_Overrun
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_ISSUE  = 2'd1,
        S_FREEZE = 2'd2,
        S_RELOAD = 2'd3
    } state_t;

    localparam logic [19:0] c_period_b0   = 20'(C_BASE_CAR_SPEED);
    localparam logic [19:0] c_period_b1   = 20'(C_BASE_CAR_SPEED >> 1);
    localparam logic [19:0] c_period_b2   = 20'(C_BASE_CAR_SPEED >> 2);
    localparam logic [19:0] c_period_b3   = 20'(C_BASE_CAR_SPEED >> 3);
    localparam logic [7:0]  c_lfsr_seed   = (C_LFSR_SEED == 8'h00) ? 8'h01 : C_LFSR_SEED;
    localparam logic [7:0]  c_freeze_last = 8'(C_FREEZE_TICKS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_lane;
    logic [1:0]          w_lane_next;
    logic [19:0]         r_period;
    logic [19:0]         w_period_sel;
    logic [19:0]         w_period_m1;
    logic [19:0]         r_count;
    logic                w_tick;
    logic [7:0]          r_lfsr;
    logic                w_lfsr_fb;
    logic                r_pending;
    logic                w_enter_freeze;
    logic [7:0]          r_ftick;
    logic [NUM_BITS-1:0] r_reverse;
    logic [3:0]          r_level;
    logic                r_overrun;
    logic [3:0]          r_enable;
    logic [3:0]          w_enable_tick;
    logic [3:0]          w_lane_exists;
    logic [3:0]          w_mask4;
    logic [3:0]          w_rev4;
    logic                w_first_found;
    logic [1:0]          w_first_lane;
    logic                w_after_found;
    logic [1:0]          w_after_lane;

    // ------------------------------------------------------------------
    // Fixed four-lane views of the lane-existence, mask and direction bits.
    // These keep lane indexing in range whatever C_NB_CARS / NUM_BITS are.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_exists[gi] = (gi < C_NB_CARS);
            if (gi < NUM_BITS) begin : g_rev_bit
                assign w_rev4[gi] = r_reverse[gi];
            end else begin : g_rev_pad
                assign w_rev4[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef OBST_SCHED_LANE_MASK_EN
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            if (gi < NUM_BITS) begin : g_mask_bit
                assign w_mask4[gi] = i_Lane_Mask[gi];
            end else begin : g_mask_pad
                assign w_mask4[gi] = 1'b0;
            end
        end
    endgenerate
`else
    assign w_mask4 = 4'b0000;
`endif

    assign w_enable_tick = w_lane_exists & ~w_mask4;

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    always_comb begin
        if (i_Score >= 6'd1 && i_Score <= 6'd3) begin
            w_period_sel = c_period_b0;
        end else if (i_Score >= 6'd4 && i_Score <= 6'd6) begin
            w_period_sel = c_period_b1;
        end else if (i_Score >= 6'd7 && i_Score <= 6'd9) begin
            w_period_sel = c_period_b2;
        end else begin
            w_period_sel = c_period_b3;
        end
    end

    // The period register is a pure pipeline of i_Score. It also loads
    // during reset, so the first count after release already uses the
    // correct band.
    always_ff @(posedge i_Clk) begin
        r_period <= w_period_sel;
    end

    assign w_period_m1 = r_period - 20'd1;
    // ">=" rather than "==": when the score shrinks the period below the
    // current count, the tick fires at once instead of wrapping 2^20.
    assign w_tick      = !i_Pause && (r_count >= w_period_m1);

    assign w_lfsr_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_enter_freeze = (r_state == S_RUN) && r_pending;

    // ------------------------------------------------------------------
    // Lane search: the first enabled lane at the tick, and the next enabled
    // lane after the current one. Masked lanes therefore cost no cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_first_found = 1'b0;
        w_first_lane  = 2'd0;
        w_after_found = 1'b0;
        w_after_lane  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_enable_tick[i]) begin
                w_first_found = 1'b1;
                w_first_lane  = 2'(i);
            end
            if (r_enable[i] && (i > int'(r_lane))) begin
                w_after_found = 1'b1;
                w_after_lane  = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= S_RUN;
            r_lane  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_lane  <= w_lane_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_lane_next  = r_lane;
        o_Step_Valid = 1'b0;
        o_Freeze     = 1'b0;
        o_Level_Ack  = 1'b0;
        case (r_state)
            S_RUN: begin
                // A pending level-up wins over a coincident tick.
                if (r_pending) begin
                    w_state_next = S_FREEZE;
                end else if (w_tick && w_first_found) begin
                    w_state_next = S_ISSUE;
                    w_lane_next  = w_first_lane;
                end
            end
            S_ISSUE: begin
                o_Step_Valid = 1'b1;
                if (i_Step_Ready) begin
                    if (w_after_found) begin
                        w_lane_next = w_after_lane;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_FREEZE: begin
                o_Freeze = 1'b1;
                if (w_tick && (r_ftick == c_freeze_last)) begin
                    w_state_next = S_RELOAD;
                end
            end
            default: begin
                o_Level_Ack  = 1'b1;
                w_state_next = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, LFSR, level-up bookkeeping and direction/level registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_count   <= 20'd0;
            r_lfsr    <= c_lfsr_seed;
            r_pending <= 1'b0;
            r_ftick   <= 8'd0;
            r_reverse <= C_INIT_REVERSE;
            r_level   <= 4'd0;
            r_overrun <= 1'b0;
            r_enable  <= 4'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};

            if (w_enter_freeze || w_tick) begin
                r_count <= 20'd0;
            end else if (!i_Pause) begin
                r_count <= r_count + 20'd1;
            end

            if (w_enter_freeze) begin
                r_pending <= 1'b0;
            end else if (i_Level_Up && (r_state != S_FREEZE) && (r_state != S_RELOAD)) begin
                r_pending <= 1'b1;
            end

            if (w_enter_freeze) begin
                r_ftick <= 8'd0;
            end else if ((r_state == S_FREEZE) && w_tick) begin
                r_ftick <= r_ftick + 8'd1;
            end

            // The mask is captured at the tick so the round is stable.
            if ((r_state == S_RUN) && w_tick) begin
                r_enable <= w_enable_tick;
            end

            if (r_state == S_RELOAD) begin
                r_reverse <= r_lfsr[NUM_BITS-1:0];
                if (r_level != 4'hF) begin
                    r_level <= r_level + 4'd1;
                end
            end

            // A tick during a round is dropped, but it is recorded.
            if ((r_state == S_ISSUE) && w_tick) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        case (r_lane)
            2'd0:    o_Step_Amount = 3'd2;
            2'd1:    o_Step_Amount = 3'd4;
            2'd2:    o_Step_Amount = 3'd2;
            default: o_Step_Amount = 3'd1;
        endcase
    end

    assign o_Step_Lane    = r_lane;
    assign o_Step_Reverse = w_rev4[r_lane];
    assign o_Reverse      = r_reverse;
    assign o_Level        = r_level;
    assign o_Overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_lane_scheduler
// Description : Directed self-checking bench for obstacle_lane_scheduler with
//               base period 16 and three freeze ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_lane_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] score;
    logic       lvl;
    logic       pause;
    logic       ready;
`ifdef OBST_SCHED_LANE_MASK_EN
    logic [3:0] lane_mask = 4'b0000;
`endif

    logic       o_Step_Valid;
    logic [1:0] o_Step_Lane;
    logic [2:0] o_Step_Amount;
    logic       o_Step_Reverse;
    logic [3:0] o_Reverse;
    logic       o_Freeze;
    logic       o_Level_Ack;
    logic [3:0] o_Level;
    logic       o_Overrun;

    int checks   = 0;
    int failures = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, runs every cycle.
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    obstacle_lane_scheduler #(
        .C_BASE_CAR_SPEED(16),
        .C_NB_CARS       (4),
        .NUM_BITS        (4),
        .C_FREEZE_TICKS  (3),
        .C_INIT_REVERSE  (4'b1010),
        .C_LFSR_SEED     (8'hA5)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Score       (score),
        .i_Level_Up    (lvl),
        .i_Pause       (pause),
        .i_Step_Ready  (ready),
`ifdef OBST_SCHED_LANE_MASK_EN
        .i_Lane_Mask   (lane_mask),
`endif
        .o_Step_Valid  (o_Step_Valid),
        .o_Step_Lane   (o_Step_Lane),
        .o_Step_Amount (o_Step_Amount),
        .o_Step_Reverse(o_Step_Reverse),
        .o_Reverse     (o_Reverse),
        .o_Freeze      (o_Freeze),
        .o_Level_Ack   (o_Level_Ack),
        .o_Level       (o_Level),
        .o_Overrun     (o_Overrun)
    );

    // Advance one clock; outputs are sampled 1 ns after the edge and inputs
    // changed there take effect on the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        step(); step(); step();
        checks++;
        if (o_Step_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_Step_Valid); end
        checks++;
        if (o_Freeze !== 1'b0 || o_Level_Ack !== 1'b0) begin failures++; $display("FAIL reset_freeze_ack got=%b%b want=00", o_Freeze, o_Level_Ack); end
        checks++;
        if (o_Overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", o_Overrun); end
        checks++;
        if (o_Level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", o_Level); end
        checks++;
        if (o_Reverse !== 4'b1010) begin failures++; $display("FAIL reset_reverse got=%b want=1010", o_Reverse); end
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (o_Step_Valid === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 16) begin failures++; $display("FAIL first_tick_latency got=%0d want=16", n); end
    endtask

    task automatic test_first_round();
        logic [6:0] exp_v [0:3];
        exp_v[0] = 7'b1_00_010_0;
        exp_v[1] = 7'b1_01_100_1;
        exp_v[2] = 7'b1_10_010_0;
        exp_v[3] = 7'b1_11_001_1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({o_Step_Valid, o_Step_Lane, o_Step_Amount, o_Step_Reverse} !== exp_v[k]) begin
                failures++;
                $display("FAIL round_lane%0d got=%b want=%b", k,
                         {o_Step_Valid, o_Step_Lane, o_Step_Amount, o_Step_Reverse}, exp_v[k]);
            end
            step();
        end
        checks++;
        if (o_Step_Valid !== 1'b0) begin failures++; $display("FAIL round_end_valid got=%b want=0", o_Step_Valid); end
    endtask

    task automatic test_pause();
        int nv;
        int n;
        step();                 // counter now 5
        pause = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_Step_Valid === 1'b1) nv++;
        end
        pause = 1'b0;
        checks++;
        if (nv != 0) begin failures++; $display("FAIL pause_no_steps got=%0d want=0", nv); end
        // Counter 5 -> 15 takes 10 clocks; the request registers on the 11th.
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (o_Step_Valid === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 11) begin failures++; $display("FAIL pause_resume_latency got=%0d want=11", n); end
    endtask

    task automatic test_ready_stall();
        step();                 // lane 0 accepted, lane 1 presented
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({o_Step_Valid, o_Step_Lane, o_Step_Amount} !== 6'b1_01_100) begin
                failures++;
                $display("FAIL stall_hold_cycle%0d got=%b want=101100", k,
                         {o_Step_Valid, o_Step_Lane, o_Step_Amount});
            end
        end
        ready = 1'b1;
        step();
        checks++;
        if ({o_Step_Valid, o_Step_Lane} !== 3'b1_10) begin
            failures++; $display("FAIL stall_release_lane got=%b want=110", {o_Step_Valid, o_Step_Lane});
        end
        step(); step();
        checks++;
        if (o_Overrun !== 1'b0) begin failures++; $display("FAIL stall_overrun got=%b want=0", o_Overrun); end
    endtask

    task automatic test_level_up();
        bit         found;
        bit         seen_ack;
        int         n_frz;
        int         n_valid;
        int         n;
        logic [3:0] exp_rev;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_Step_Valid === 1'b1) begin found = 1'b1; break; end
        end
        step(); step();
        checks++;
        if (!found || {o_Step_Valid, o_Step_Lane} !== 3'b1_10) begin
            failures++; $display("FAIL lvl_round_lane2 got=%b want=110", {o_Step_Valid, o_Step_Lane});
        end
        lvl = 1'b1;
        step();
        lvl = 1'b0;
        checks++;
        if ({o_Step_Valid, o_Step_Lane, o_Freeze} !== 4'b1_11_0) begin
            failures++; $display("FAIL lvl_round_completes got=%b want=1110", {o_Step_Valid, o_Step_Lane, o_Freeze});
        end
        n_frz    = 0;
        n_valid  = 0;
        seen_ack = 1'b0;
        exp_rev  = 4'b0000;
        for (int k = 0; k < 200; k++) begin
            step();
            if (o_Freeze === 1'b1) n_frz++;
            if (o_Step_Valid === 1'b1 && k > 0) n_valid++;
            // A second request deep inside the freeze must be ignored.
            lvl = (n_frz == 10);
            if (o_Level_Ack === 1'b1) begin seen_ack = 1'b1; exp_rev = m_lfsr[3:0]; break; end
        end
        lvl = 1'b0;
        checks++;
        if (seen_ack !== 1'b1) begin failures++; $display("FAIL lvl_ack_seen got=%b want=1", seen_ack); end
        checks++;
        if (n_frz != 48) begin failures++; $display("FAIL lvl_freeze_cycles got=%0d want=48", n_frz); end
        checks++;
        if (n_valid != 0) begin failures++; $display("FAIL lvl_steps_in_freeze got=%0d want=0", n_valid); end
        step();
        checks++;
        if (o_Level_Ack !== 1'b0) begin failures++; $display("FAIL lvl_ack_single got=%b want=0", o_Level_Ack); end
        checks++;
        if (o_Level !== 4'd1) begin failures++; $display("FAIL lvl_level got=%0d want=1", o_Level); end
        checks++;
        if (o_Reverse !== exp_rev) begin failures++; $display("FAIL lvl_reverse got=%b want=%b", o_Reverse, exp_rev); end
        // Reload cycle was a tick edge (count 0), so the next request is 16 clocks later.
        n_frz = 0;
        n = 0;
        for (int k = 2; k <= 40; k++) begin
            step();
            if (o_Freeze === 1'b1) n_frz++;
            if (o_Step_Valid === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 16 || n_frz != 0) begin
            failures++; $display("FAIL lvl_resume got=%0d/%0d want=16/0", n, n_frz);
        end
    endtask

    task automatic test_overrun();
        checks++;
        if (o_Overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b want=0", o_Overrun); end
        for (int k = 0; k < 10; k++) step();   // counter now 10
        score = 6'd10;
        step();
        checks++;
        if (o_Step_Valid !== 1'b0) begin failures++; $display("FAIL ovr_no_early_tick got=%b want=0", o_Step_Valid); end
        step();
        checks++;
        if ({o_Step_Valid, o_Step_Lane} !== 3'b1_00) begin
            failures++; $display("FAIL ovr_fast_tick got=%b want=100", {o_Step_Valid, o_Step_Lane});
        end
        step(); step(); step();
        checks++;
        if (o_Overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", o_Overrun); end
    endtask

    task automatic test_reset_mid_round();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_Step_Valid === 1'b1 && o_Step_Lane === 2'd2) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rst_mid_find_lane2 got=0 want=1"); end
        rst = 1'b1;
        step();
        checks++;
        if (o_Step_Valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", o_Step_Valid); end
        checks++;
        if (o_Reverse !== 4'b1010) begin failures++; $display("FAIL rst_mid_reverse got=%b want=1010", o_Reverse); end
        checks++;
        if (o_Level !== 4'd0 || o_Overrun !== 1'b0) begin
            failures++; $display("FAIL rst_mid_level_ovr got=%0d/%b want=0/0", o_Level, o_Overrun);
        end
        rst = 1'b0;
        step(); step();
    endtask

    initial begin
        rst   = 1'b1;
        score = 6'd2;
        lvl   = 1'b0;
        pause = 1'b0;
        ready = 1'b1;
        test_reset();
        test_first_round();
        test_pause();
        test_ready_stall();
        test_level_up();
        test_overrun();
        test_reset_mid_round();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
